// File: rtl/imem_fetch.sv
// ============================================================================
// imem_fetch
// ----------------------------------------------------------------------------
// Pipelined instruction memory for the RISC-V cores. Memory is byte
// addressable and little-endian, stored internally as 32-bit words. Each
// accepted request returns FETCH_WIDTH consecutive instructions, LATENCY
// cycles after the accepting edge, through a small response queue.
//
// Parameters
//   MEM_SIZE     array size in bytes (multiple of 4*FETCH_WIDTH)
//   FETCH_WIDTH  instructions returned per request
//   LATENCY      accepting edge to rsp_valid, in cycles (1..4)
//
// Ports
//   clk          single clock, all state changes on posedge
//   reset        synchronous, active-high
//   req_valid    fetch request present
//   req_ready    request can be accepted this cycle
//   req_addr     byte address of the first instruction
//   rsp_valid    a response sits at the queue head
//   rsp_ready    consumer takes the head response
//   rsp_instr    slot k = instruction at req_addr + 4k (zero on fault)
//   rsp_addr     req_addr of the head response
//   rsp_fault    head response is misaligned or out of range
//   flush        drop every in-flight and queued response (branch redirect)
//   prog_we      program-port word write strobe
//   prog_addr    program-port byte address, bits [1:0] ignored
//   prog_wdata   program-port write data
// ============================================================================
module imem_fetch #(
    parameter int MEM_SIZE    = 1024,
    parameter int FETCH_WIDTH = 1,
    parameter int LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [32*FETCH_WIDTH-1:0] rsp_instr,
    output logic [31:0]               rsp_addr,
    output logic                      rsp_fault,
    input  logic                      flush,
    input  logic                      prog_we,
    input  logic [31:0]               prog_addr,
    input  logic [31:0]               prog_wdata
);

    localparam int RSP_DEPTH = LATENCY + 1;
    localparam int WORDS     = MEM_SIZE / 4;
    localparam int AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW        = $clog2(RSP_DEPTH);
    localparam int CW        = $clog2(RSP_DEPTH + 1) + 1;
    localparam int IW        = 32 * FETCH_WIDTH;

    // ------------------------------------------------------------------------
    // Instruction array and program port
    // ------------------------------------------------------------------------
    logic [31:0] mem [WORDS];

    logic [32:0] progAddrWide;
    logic        progInRange;

    assign progAddrWide = {1'b0, prog_addr};
    assign progInRange  = (progAddrWide <= 33'(MEM_SIZE - 4));

    // The array is deliberately left out of reset so a boot image survives a
    // core reset. Fetch reads below see the pre-edge contents, so a write
    // landing on the same edge as a fetch of that word returns the old word.
    always_ff @(posedge clk) begin
        if (prog_we && progInRange) begin
            mem[prog_addr[AW+1:2]] <= prog_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Request decode and array read
    // ------------------------------------------------------------------------
    logic          reqFire;
    logic [32:0]   reqEndWide;
    logic          reqMisaligned;
    logic          reqOutOfRange;
    logic          reqFault;
    logic [AW-1:0] baseIdx;
    logic [IW-1:0] readData;

    assign reqFire       = req_valid && req_ready;
    // The end address is formed in 33 bits so requests near 4 GiB cannot
    // wrap around and look in range.
    assign reqEndWide    = {1'b0, req_addr} + 33'(4 * FETCH_WIDTH);
    assign reqMisaligned = (req_addr[1:0] != 2'b00);
    assign reqOutOfRange = (reqEndWide > 33'(MEM_SIZE));
    assign reqFault      = reqMisaligned || reqOutOfRange;
    assign baseIdx       = req_addr[AW+1:2];

    // A faulting request never touches the array; its slots read as zero.
    always_comb begin
        readData = '0;
        if (!reqFault) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                readData[32*k +: 32] = mem[baseIdx + AW'(k)];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fixed-latency read pipeline (never stalls)
    // ------------------------------------------------------------------------
    logic          pipeValid_q [LATENCY];
    logic          pipeValid_d [LATENCY];
    logic [IW-1:0] pipeInstr_q [LATENCY];
    logic [IW-1:0] pipeInstr_d [LATENCY];
    logic [31:0]   pipeAddr_q  [LATENCY];
    logic [31:0]   pipeAddr_d  [LATENCY];
    logic          pipeFault_q [LATENCY];
    logic          pipeFault_d [LATENCY];

    // Stage 0 captures the request accepted at this edge even when flush is
    // high: that request is the redirect target and must survive. Every older
    // stage is wiped by flush.
    always_comb begin
        pipeValid_d = pipeValid_q;
        pipeInstr_d = pipeInstr_q;
        pipeAddr_d  = pipeAddr_q;
        pipeFault_d = pipeFault_q;

        pipeValid_d[0] = reqFire;
        pipeInstr_d[0] = readData;
        pipeAddr_d[0]  = req_addr;
        pipeFault_d[0] = reqFault;

        for (int s = 1; s < LATENCY; s++) begin
            pipeValid_d[s] = pipeValid_q[s-1] && !flush;
            pipeInstr_d[s] = pipeInstr_q[s-1];
            pipeAddr_d[s]  = pipeAddr_q[s-1];
            pipeFault_d[s] = pipeFault_q[s-1];
        end
    end

    // Only the valid bits need reset; payload is qualified by them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipeValid_q[s] <= 1'b0;
            end
        end else begin
            pipeValid_q <= pipeValid_d;
        end
        pipeInstr_q <= pipeInstr_d;
        pipeAddr_q  <= pipeAddr_d;
        pipeFault_q <= pipeFault_d;
    end

    // ------------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------------
    logic [IW-1:0] fifoInstr_q [RSP_DEPTH];
    logic [31:0]   fifoAddr_q  [RSP_DEPTH];
    logic          fifoFault_q [RSP_DEPTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic fifoPush;
    logic fifoPop;

    // Depth is LATENCY+1, generally not a power of two, so pointers wrap
    // explicitly.
    function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign fifoPush = pipeValid_q[LATENCY-1] && !flush;
    assign fifoPop  = rsp_valid && rsp_ready;

    // A pop in a flush cycle is honoured, but since flush empties the queue
    // anyway it needs no special case beyond the clear.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;

        if (fifoPush) begin
            wrPtr_d = ptrNext(wrPtr_q);
        end
        if (fifoPop) begin
            rdPtr_d = ptrNext(rdPtr_q);
        end
        if (fifoPush && !fifoPop) begin
            count_d = count_q + CW'(1);
        end else if (!fifoPush && fifoPop) begin
            count_d = count_q - CW'(1);
        end

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            fifoInstr_q[wrPtr_q] <= pipeInstr_q[LATENCY-1];
            fifoAddr_q[wrPtr_q]  <= pipeAddr_q[LATENCY-1];
            fifoFault_q[wrPtr_q] <= pipeFault_q[LATENCY-1];
        end
    end

    // ------------------------------------------------------------------------
    // Flow control and outputs
    // ------------------------------------------------------------------------
    logic [CW-1:0] inFlight;

    always_comb begin
        inFlight = '0;
        for (int s = 0; s < LATENCY; s++) begin
            inFlight = inFlight + CW'(pipeValid_q[s]);
        end
    end

    // Every accepted request owns a FIFO slot from acceptance onward, so the
    // FIFO can never overflow. Built from registered state only: a pop in the
    // current cycle does not open the door until the next cycle.
    assign req_ready = !reset && ((inFlight + count_q) < CW'(RSP_DEPTH));

    assign rsp_valid = (count_q != '0);

    // Outputs are forced to zero when idle so the post-reset values are clean.
    assign rsp_instr = rsp_valid ? fifoInstr_q[rdPtr_q] : '0;
    assign rsp_addr  = rsp_valid ? fifoAddr_q[rdPtr_q]  : '0;
    assign rsp_fault = rsp_valid ? fifoFault_q[rdPtr_q] : 1'b0;

endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;

   localparam int MEM_SIZE    = 1024;
   localparam int FETCH_WIDTH = 2;
   localparam int LATENCY     = 2;
   localparam int RSP_DEPTH   = LATENCY + 1;
   localparam int WORDS       = MEM_SIZE / 4;
   localparam int IW          = 32 * FETCH_WIDTH;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [IW-1:0] rsp_instr;
   logic [31:0]   rsp_addr;
   logic          rsp_fault;
   logic          flush;
   logic          prog_we;
   logic [31:0]   prog_addr;
   logic [31:0]   prog_wdata;

   imem_fetch #(
      .MEM_SIZE   (MEM_SIZE),
      .FETCH_WIDTH(FETCH_WIDTH),
      .LATENCY    (LATENCY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_addr  (rsp_addr),
      .rsp_fault (rsp_fault),
      .flush     (flush),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_wdata(prog_wdata)
   );

   always #5 clk = ~clk;

   // Reference model: every outstanding request is one queue entry carrying
   // its final response and the edge count from which it may be seen.
   typedef struct {
      logic [IW-1:0] instr;
      logic [31:0]   addr;
      logic          fault;
      int            visibleAt;
   } rsp_t;

   rsp_t        modelQ[$];
   logic [31:0] modelMem [WORDS];
   int          cycle       = 0;
   int          checks      = 0;
   int          errors      = 0;
   bit          checkEnable = 1'b0;

   // One comparison: counts it, and reports a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
      end
   endtask

   // What a fetch of addr must return, straight from the memory map rules.
   function automatic rsp_t modelFetch(input logic [31:0] addr);
      rsp_t        r;
      logic [63:0] endAddr;
      r.addr      = addr;
      r.instr     = '0;
      r.visibleAt = 0;
      endAddr     = 64'(addr) + 64'(4 * FETCH_WIDTH);
      r.fault     = (addr % 4 != 0) || (endAddr > 64'(MEM_SIZE));
      if (!r.fault) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            r.instr[32*k +: 32] = modelMem[addr / 4 + k];
         end
      end
      return r;
   endfunction

   // Model advances once per edge from the inputs held during the cycle.
   always @(posedge clk) begin : modelStep
      bit   modelReady;
      bit   modelValid;
      rsp_t r;
      modelReady = !reset && (modelQ.size() < RSP_DEPTH);
      modelValid = (modelQ.size() > 0) && (modelQ[0].visibleAt <= cycle);
      if (reset) begin
         modelQ.delete();
      end else begin
         r = modelFetch(req_addr);
         if (modelValid && rsp_ready) void'(modelQ.pop_front());
         if (flush) modelQ.delete();
         if (req_valid && modelReady) begin
            r.visibleAt = cycle + LATENCY + 1;
            modelQ.push_back(r);
         end
      end
      if (prog_we && (prog_addr <= 32'(MEM_SIZE - 4))) begin
         modelMem[prog_addr / 4] = prog_wdata;
      end
      cycle = cycle + 1;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin : compare
      if (checkEnable) begin
         bit expReady;
         bit expValid;
         expReady = !reset && (modelQ.size() < RSP_DEPTH);
         expValid = (modelQ.size() > 0) && (modelQ[0].visibleAt <= cycle);
         checkOutput("req_ready", req_ready, expReady);
         checkOutput("rsp_valid", rsp_valid, expValid);
         if (expValid) begin
            checkOutput("rsp_instr", rsp_instr, modelQ[0].instr);
            checkOutput("rsp_addr", rsp_addr, modelQ[0].addr);
            checkOutput("rsp_fault", rsp_fault, modelQ[0].fault);
         end else if (reset) begin
            checkOutput("reset_rsp_instr", rsp_instr, 0);
            checkOutput("reset_rsp_addr", rsp_addr, 0);
            checkOutput("reset_rsp_fault", rsp_fault, 0);
         end
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                                input logic pwe, input logic [31:0] pa, input logic [31:0] pd);
      req_valid  = rv;
      req_addr   = ra;
      rsp_ready  = rr;
      flush      = fl;
      prog_we    = pwe;
      prog_addr  = pa;
      prog_wdata = pd;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic progWrite(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, addr, data);
      nextCycle();
   endtask

   task automatic issueRequest(input logic [31:0] addr, output bit ok);
      ok        = 1'b0;
      req_valid = 1'b1;
      req_addr  = addr;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) ok = 1'b1;
         nextCycle();
      end
      req_valid = 1'b0;
   endtask

   task automatic waitResponse(output logic [IW-1:0] instr, output logic [31:0] addr, output logic fault,
                               output int waited, output bit ok);
      ok = 1'b0; waited = -1; instr = '0; addr = '0; fault = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            ok = 1'b1; instr = rsp_instr; addr = rsp_addr; fault = rsp_fault; waited = i;
         end
         nextCycle();
      end
   endtask

   // Single fetch from an empty queue with literal expectations, latency included.
   task automatic fetchCheck(input string name, input logic [31:0] addr, input logic [IW-1:0] expInstr,
                             input logic expFault);
      bit            accOk;
      bit            rspOk;
      logic [IW-1:0] instr;
      logic [31:0]   raddr;
      logic          fault;
      int            waited;
      issueRequest(addr, accOk);
      checkOutput({name, "_accepted"}, accOk, 1);
      waitResponse(instr, raddr, fault, waited, rspOk);
      checkOutput({name, "_responded"}, rspOk, 1);
      checkOutput({name, "_instr"}, instr, expInstr);
      checkOutput({name, "_addr"}, raddr, addr);
      checkOutput({name, "_fault"}, fault, expFault);
      checkOutput({name, "_latency"}, waited, LATENCY);
   endtask

   initial begin : watchdog
      #1000000;
      errors = errors + 1;
      $display("[TB] FAIL watchdog: time limit hit, got no finish, expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] seenAddr[$];
      logic [31:0] seenInstr[$];
      int          seenCycle[$];
      int          accepts;
      int          seen;
      bit          fire;
      bit          rspOk;
      logic [IW-1:0] instr;
      logic [31:0] raddr;
      logic        fault;
      int          waited;
      logic [31:0] data;

      reset = 1'b1;
      idle();
      nextCycle();
      checkEnable = 1'b1;
      repeat (2) nextCycle();
      @(negedge clk);
      checkOutput("inReset_req_ready", req_ready, 0);
      checkOutput("inReset_rsp_valid", rsp_valid, 0);
      nextCycle();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("afterReset_req_ready", req_ready, 1);
      nextCycle();

      // Boot image: known words at the interesting places, random elsewhere.
      for (int w = 0; w < WORDS; w++) begin
         case (w)
            0:         data = 32'h00500093;
            1:         data = 32'h00108113;
            4:         data = 32'h0A0A0A0A;
            5:         data = 32'h05050505;
            WORDS - 2: data = 32'h11111111;
            WORDS - 1: data = 32'h22222222;
            default:   data = $urandom;
         endcase
         progWrite(32'(4 * w), data);
      end
      progWrite(32'(MEM_SIZE - 3), 32'hBAD0BAD0);
      progWrite(32'(MEM_SIZE - 1), 32'hBAD1BAD1);
      progWrite(32'(MEM_SIZE), 32'hBAD2BAD2);
      idle();
      nextCycle();

      fetchCheck("fetch0", 32'h0, {32'h00108113, 32'h00500093}, 1'b0);
      fetchCheck("misaligned2", 32'h2, '0, 1'b1);
      fetchCheck("range3FC", 32'(MEM_SIZE - 4), '0, 1'b1);
      fetchCheck("last3F8", 32'(MEM_SIZE - 8), {32'h22222222, 32'h11111111}, 1'b0);
      fetchCheck("wrapTop", 32'hFFFFFFF8, '0, 1'b1);

      // Back-to-back requests with the consumer always ready.
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      req_addr = 32'h4;
      nextCycle();
      req_valid = 1'b0;
      seenAddr.delete(); seenInstr.delete();
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            seenAddr.push_back(rsp_addr);
            seenInstr.push_back(rsp_instr[31:0]);
         end
         nextCycle();
      end
      checkOutput("b2b_count", seenAddr.size(), 2);
      if (seenAddr.size() == 2) begin
         checkOutput("b2b_addr0", seenAddr[0], 32'h0);
         checkOutput("b2b_addr1", seenAddr[1], 32'h4);
         checkOutput("b2b_instr0", seenInstr[0], 32'h00500093);
         checkOutput("b2b_instr1", seenInstr[1], 32'h00108113);
      end

      // Backpressure: consumer stalled while requests are held.
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      accepts = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         fire = (req_ready === 1'b1);
         nextCycle();
         if (fire) begin
            accepts  = accepts + 1;
            req_addr = 32'(4 * accepts);
         end
      end
      req_valid = 1'b0;
      checkOutput("bp_accepts", accepts, RSP_DEPTH);
      @(negedge clk);
      checkOutput("bp_req_ready_low", req_ready, 0);
      nextCycle();
      rsp_ready = 1'b1;
      seenAddr.delete();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) checkOutput("bp_ready_in_pop_cycle", req_ready, 0);
         if (i == 1) checkOutput("bp_ready_after_pop", req_ready, 1);
         if (rsp_valid === 1'b1) seenAddr.push_back(rsp_addr);
         nextCycle();
      end
      checkOutput("bp_count", seenAddr.size(), RSP_DEPTH);
      foreach (seenAddr[k]) checkOutput("bp_order", seenAddr[k], 32'(4 * k));

      // Flush with two requests in flight and a redirect in the same cycle.
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      req_addr = 32'h104;
      nextCycle();
      req_addr = 32'h40;
      flush    = 1'b1;
      nextCycle();
      req_valid = 1'b0;
      flush     = 1'b0;
      seenAddr.delete(); seenCycle.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            seenAddr.push_back(rsp_addr);
            seenCycle.push_back(i);
         end
         nextCycle();
      end
      checkOutput("flush_count", seenAddr.size(), 1);
      if (seenAddr.size() == 1) begin
         checkOutput("flush_addr", seenAddr[0], 32'h40);
         checkOutput("flush_latency", seenCycle[0], LATENCY);
      end

      // Write and fetch of the same word on the same edge.
      applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      nextCycle();
      idle();
      waitResponse(instr, raddr, fault, waited, rspOk);
      checkOutput("sameEdge_responded", rspOk, 1);
      checkOutput("sameEdge_oldWord", instr, {32'h05050505, 32'h0A0A0A0A});
      fetchCheck("afterWrite", 32'h10, {32'h05050505, 32'hDEADBEEF}, 1'b0);

      // Reset with a full queue drops everything; array survives.
      applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      nextCycle();
      req_addr = 32'h24;
      nextCycle();
      req_addr = 32'h28;
      nextCycle();
      req_valid = 1'b0;
      repeat (3) nextCycle();
      @(negedge clk);
      checkOutput("preReset_rsp_valid", rsp_valid, 1);
      checkOutput("preReset_req_ready", req_ready, 0);
      nextCycle();
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("postReset_rsp_valid", rsp_valid, 0);
      checkOutput("postReset_req_ready", req_ready, 1);
      nextCycle();
      rsp_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = seen + 1;
         nextCycle();
      end
      checkOutput("postReset_noStale", seen, 0);
      fetchCheck("afterReset0", 32'h0, {32'h00108113, 32'h00500093}, 1'b0);

      // Reset and flush together: the same-cycle request is dropped.
      applyStimulus(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      idle();
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = seen + 1;
         nextCycle();
      end
      checkOutput("resetFlush_dropped", seen, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         int sel;
         sel       = int'($urandom_range(0, 99));
         req_valid = ($urandom_range(0, 99) < 70);
         if (sel < 75)      req_addr = 32'(4 * $urandom_range(0, WORDS - 1));
         else if (sel < 90) req_addr = 32'(4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3));
         else if (sel < 95) req_addr = 32'(MEM_SIZE - 4 * $urandom_range(0, 2));
         else               req_addr = $urandom;
         rsp_ready  = ($urandom_range(0, 99) < 60);
         flush      = ($urandom_range(0, 99) < 4);
         reset      = ($urandom_range(0, 999) < 5);
         prog_we    = ($urandom_range(0, 99) < 15);
         prog_addr  = ($urandom_range(0, 9) == 0) ? 32'(MEM_SIZE - 4 + $urandom_range(0, 15))
                                                  : 32'($urandom_range(0, MEM_SIZE - 1));
         prog_wdata = $urandom;
         nextCycle();
      end
      reset = 1'b0;
      idle();
      repeat (10) nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
